// File: rtl/dma_copy_engine.sv
// Memory-to-memory copy engine. It is programmed through a small register file and
// moves LEN words from SRC to DST, one read/write pair at a time, while memory is granted.
module dma_copy_engine #(
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int ADDR_WIDTH         = 16,
  parameter int C_LEN_WIDTH        = 12
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic [ADDR_WIDTH-3:0]         reg_addr,
  input  logic [C_M_AXI_DATA_WIDTH-1:0] reg_data,
  input  logic                          reg_write,
  input  logic                          mem_enable_ack,
  output logic                          mem_requst_ack,
  output logic [ADDR_WIDTH-3:0]         dma_raddr,
  output logic                          dma_rden,
  input  logic [31:0]                   dma_rdata,
  output logic [ADDR_WIDTH-3:0]         dma_waddr,
  output logic                          dma_wren,
  output logic [31:0]                   dma_wdata,
  output logic                          dma_busy,
  output logic                          dma_done,
  output logic                          dma_irq
);
  localparam int AW = ADDR_WIDTH - 2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_WR   = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e                 state_q, state_d;
  logic [AW-1:0]          src_q, src_d;
  logic [AW-1:0]          dst_q, dst_d;
  logic [C_LEN_WIDTH-1:0] len_q, len_d;
  logic [AW-1:0]          cur_src_q, cur_src_d;
  logic [AW-1:0]          cur_dst_q, cur_dst_d;
  logic [C_LEN_WIDTH-1:0] remaining_q, remaining_d;
  logic [31:0]            wbuf_q, wbuf_d;
  logic                   done_q, done_d;

  logic busy_s;
  logic ctrl_wr_s;
  logic start_s;
  logic clear_s;
  logic abort_s;
  logic unused_s;

  assign busy_s    = (state_q != S_IDLE);
  assign ctrl_wr_s = reg_write && (reg_addr[1:0] == 2'b11);
  assign start_s   = ctrl_wr_s && reg_data[0];
  assign clear_s   = ctrl_wr_s && reg_data[1];
  assign abort_s   = ctrl_wr_s && reg_data[2];
  assign unused_s  = ^{reg_addr[AW-1:2], reg_data[C_M_AXI_DATA_WIDTH-1:AW]};

  assign dma_busy = busy_s;
  assign dma_done = done_q;

  // Next-state, register-file and memory-port decode.
  always_comb begin
    state_d        = state_q;
    src_d          = src_q;
    dst_d          = dst_q;
    len_d          = len_q;
    cur_src_d      = cur_src_q;
    cur_dst_d      = cur_dst_q;
    remaining_d    = remaining_q;
    wbuf_d         = wbuf_q;
    done_d         = done_q;
    mem_requst_ack = 1'b0;
    dma_rden       = 1'b0;
    dma_raddr      = {AW{1'b0}};
    dma_wren       = 1'b0;
    dma_waddr      = {AW{1'b0}};
    dma_wdata      = 32'h0000_0000;
    dma_irq        = 1'b0;

    // Transfer parameters are frozen while a transfer is running.
    if (reg_write && !busy_s) begin
      case (reg_addr[1:0])
        2'b00:   src_d = reg_data[AW-1:0];
        2'b01:   dst_d = reg_data[AW-1:0];
        2'b10:   len_d = reg_data[C_LEN_WIDTH-1:0];
        default: len_d = len_q;
      endcase
    end else begin
      len_d = len_q;
    end

    case (state_q)
      S_IDLE: begin
        if (start_s) begin
          cur_src_d   = src_q;
          cur_dst_d   = dst_q;
          remaining_d = len_q;
          done_d      = 1'b0;
          state_d     = (len_q == {C_LEN_WIDTH{1'b0}}) ? S_DONE : S_RD;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RD: begin
        mem_requst_ack = 1'b1;
        dma_rden       = mem_enable_ack;
        dma_raddr      = cur_src_q;
        if (mem_enable_ack) begin
          wbuf_d    = dma_rdata;
          cur_src_d = cur_src_q + AW'(1);
          state_d   = S_WR;
        end else begin
          state_d = S_RD;
        end
      end
      S_WR: begin
        mem_requst_ack = 1'b1;
        dma_wren       = mem_enable_ack;
        dma_waddr      = cur_dst_q;
        dma_wdata      = wbuf_q;
        if (mem_enable_ack) begin
          cur_dst_d   = cur_dst_q + AW'(1);
          remaining_d = remaining_q - C_LEN_WIDTH'(1);
          state_d     = (remaining_q == C_LEN_WIDTH'(1)) ? S_DONE : S_RD;
        end else begin
          state_d = S_WR;
        end
      end
      S_DONE: begin
        dma_irq = 1'b1;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Abort only applies to a running transfer; an idle start with abort set still starts.
    if (abort_s && busy_s) begin
      state_d = S_IDLE;
      done_d  = done_q;
    end else begin
      state_d = state_d;
    end

    if (clear_s) begin
      done_d = 1'b0;
    end else begin
      done_d = done_d;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      src_q       <= {AW{1'b0}};
      dst_q       <= {AW{1'b0}};
      len_q       <= {C_LEN_WIDTH{1'b0}};
      cur_src_q   <= {AW{1'b0}};
      cur_dst_q   <= {AW{1'b0}};
      remaining_q <= {C_LEN_WIDTH{1'b0}};
      wbuf_q      <= 32'h0000_0000;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      src_q       <= src_d;
      dst_q       <= dst_d;
      len_q       <= len_d;
      cur_src_q   <= cur_src_d;
      cur_dst_q   <= cur_dst_d;
      remaining_q <= remaining_d;
      wbuf_q      <= wbuf_d;
      done_q      <= done_d;
    end
  end
endmodule
